// File: rtl/pe_seq_pkg.sv
// Shared encodings and default widths for the PE16 array sequencer.
package pe_seq_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 7;
    localparam int LEN_W_DEF  = 6;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_SHIFT = 2'd2,
        OP_ALU   = 2'd3
    } op_e;

    // Values are what the PEs see on the state bus.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALU   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LOAD  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_EAST  = 2'd0,
        DIR_WEST  = 2'd1,
        DIR_SOUTH = 2'd2,
        DIR_NORTH = 2'd3
    } dir_e;

    // One-hot strobe vector ordered {north, south, west, east}.
    function automatic logic [3:0] dir_onehot(input dir_e d);
        logic [3:0] oh;
        case (d)
            DIR_EAST:  oh = 4'b0001;
            DIR_WEST:  oh = 4'b0010;
            DIR_SOUTH: oh = 4'b0100;
            default:   oh = 4'b1000;
        endcase
        return oh;
    endfunction

    // State entered on accept; zero-length LOAD/SHIFT complete straight from IDLE.
    function automatic state_e cmd_state(input op_e op, input logic len_zero);
        state_e s;
        case (op)
            OP_LOAD:  s = len_zero ? ST_IDLE : ST_LOAD;
            OP_SHIFT: s = len_zero ? ST_IDLE : ST_SHIFT;
            OP_ALU:   s = ST_ALU;
            default:  s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Host-side command channel and load-data stream of the PE16 sequencer.
interface pe_array_sequencer_if import pe_seq_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_dir;
    logic [3:0]        cmd_alu_sel;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_len;
    logic [LEN_W-1:0]  word_len;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_alu_sel, cmd_src_a, cmd_src_b,
               cmd_dst, cmd_len, word_len, load_valid, load_data,
        input  cmd_ready, load_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_alu_sel, cmd_src_a, cmd_src_b,
               cmd_dst, cmd_len, word_len, load_valid, load_data,
        output cmd_ready, load_ready
    );
endinterface

// File: rtl/pe_seq_addr_gen.sv
// BRAM address and ALU phase-count generator; registered outputs advanced by
// start/step/clear strobes from the sequencer FSM.
module pe_seq_addr_gen import pe_seq_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              start,
    input  logic              step,
    input  state_e            mode,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic [CNT_W-1:0]  count
);
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] d_base;
    logic [ADDR_W-1:0] idx;

    // Base capture at accept, then per-mode address/count stepping.
    // ALU writes begin when count steps 2->3; after that idx is non-zero, which
    // keeps writes going even if count wraps on the longest word length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_base <= '0;
            d_base <= '0;
            idx    <= '0;
            addra  <= '0;
            addrb  <= '0;
            count  <= '0;
        end else if (clear) begin
            idx   <= '0;
            addra <= '0;
            addrb <= '0;
            count <= '0;
        end else if (start) begin
            a_base <= src_a;
            d_base <= dst;
            idx    <= '0;
            count  <= '0;
            case (mode)
                ST_SHIFT: begin
                    addra <= src_a;
                    addrb <= src_a + ADDR_W'(1);
                end
                ST_ALU: begin
                    addra <= src_a;
                    addrb <= src_b;
                end
                default: begin
                    addra <= '0;
                    addrb <= '0;
                end
            endcase
        end else if (step) begin
            case (mode)
                ST_LOAD: begin
                    addra <= a_base + idx;
                    idx   <= idx + ADDR_W'(1);
                end
                ST_SHIFT: begin
                    addra <= addra + ADDR_W'(2);
                    addrb <= addrb + ADDR_W'(2);
                end
                ST_ALU: begin
                    count <= count + CNT_W'(1);
                    if ((idx != '0) || (count == CNT_W'(2))) begin
                        addra <= d_base + idx;
                        idx   <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/pe_array_sequencer.sv
// Command sequencer for the PE16 array control bus.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ready for a command; NOP / zero-length commands finish here
//   ST_LOAD  | stream load beats into BRAM through BRAM_IN
//   ST_SHIFT | READ/WRITE cycle pair per word-pair with one direction strobe
//   ST_ALU   | count 0..2*length+2; writes from count 3; Op sampled at end
//
// All bus outputs are registered, so each write appears on the bus the cycle
// after the beat/step that produced it; done follows the last write cycle.
module pe_array_sequencer import pe_seq_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    pe_array_sequencer_if.slave host,
    input  logic                op_in,
    output logic                wea,
    output logic                web,
    output logic [ADDR_W-1:0]   addra,
    output logic [ADDR_W-1:0]   addrb,
    output logic [3:0]          alu_sel,
    output logic [CNT_W-1:0]    count,
    output logic [1:0]          state,
    output logic                east,
    output logic                west,
    output logic                south,
    output logic                north,
    output logic                ram_init,
    output logic [DATA_W-1:0]   bram_in,
    output logic [LEN_W-1:0]    length,
    output logic                done,
    output logic                op_flag
);
    // Remaining-work down-counter must hold cmd_len and 2*max(word_len)+2.
    localparam int REM_W = (ADDR_W > LEN_W + 2) ? ADDR_W : LEN_W + 2;

    state_e           fsm;
    dir_e             dir_q;
    logic [REM_W-1:0] remain;
    logic             wr_phase;

    state_e           target;
    state_e           ag_mode;
    logic             accept;
    logic             finishing;
    logic             ag_step;

    assign state           = fsm;
    assign host.cmd_ready  = (fsm == ST_IDLE);
    assign host.load_ready = (fsm == ST_LOAD) && (remain != '0);
    assign accept          = (fsm == ST_IDLE) && host.cmd_valid;
    assign target          = cmd_state(op_e'(host.cmd_op), host.cmd_len == '0);
    assign ag_mode         = accept ? target : fsm;

    // Terminal-count and step decisions for the current cycle.
    always_comb begin
        finishing = 1'b0;
        ag_step   = 1'b0;
        case (fsm)
            ST_LOAD: begin
                if (remain == '0)
                    finishing = 1'b1;
                else if (host.load_valid)
                    ag_step = 1'b1;
            end
            ST_SHIFT: begin
                if (wr_phase) begin
                    if (remain == REM_W'(1))
                        finishing = 1'b1;
                    else
                        ag_step = 1'b1;
                end
            end
            ST_ALU: begin
                if (remain == '0)
                    finishing = 1'b1;
                else
                    ag_step = 1'b1;
            end
            default: ;
        endcase
    end

    pe_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (finishing),
        .start  (accept),
        .step   (ag_step),
        .mode   (ag_mode),
        .src_a  (host.cmd_src_a),
        .src_b  (host.cmd_src_b),
        .dst    (host.cmd_dst),
        .addra  (addra),
        .addrb  (addrb),
        .count  (count)
    );

    // Sequencer FSM with registered control-bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm      <= ST_IDLE;
            dir_q    <= DIR_EAST;
            remain   <= '0;
            wr_phase <= 1'b0;
            wea      <= 1'b0;
            web      <= 1'b0;
            alu_sel  <= '0;
            east     <= 1'b0;
            west     <= 1'b0;
            south    <= 1'b0;
            north    <= 1'b0;
            ram_init <= 1'b0;
            bram_in  <= '0;
            length   <= '0;
            done     <= 1'b0;
            op_flag  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (finishing) begin
                fsm      <= ST_IDLE;
                done     <= 1'b1;
                remain   <= '0;
                wr_phase <= 1'b0;
                wea      <= 1'b0;
                web      <= 1'b0;
                alu_sel  <= '0;
                {north, south, west, east} <= 4'b0000;
                ram_init <= 1'b0;
                bram_in  <= '0;
                if (fsm == ST_ALU)
                    op_flag <= op_in;
            end else begin
                case (fsm)
                    ST_IDLE: begin
                        if (accept) begin
                            fsm      <= target;
                            length   <= host.word_len;
                            dir_q    <= dir_e'(host.cmd_dir);
                            wr_phase <= 1'b0;
                            alu_sel  <= (target == ST_ALU) ? host.cmd_alu_sel : 4'h0;
                            case (target)
                                ST_ALU: remain <= REM_W'({host.word_len, 1'b0}) + REM_W'(2);
                                ST_IDLE: begin
                                    remain <= '0;
                                    done   <= 1'b1;
                                end
                                default: remain <= REM_W'(host.cmd_len);
                            endcase
                        end
                    end
                    ST_LOAD: begin
                        if (host.load_valid) begin
                            wea      <= 1'b1;
                            ram_init <= 1'b1;
                            bram_in  <= host.load_data;
                            remain   <= remain - REM_W'(1);
                        end else begin
                            wea      <= 1'b0;
                            ram_init <= 1'b0;
                        end
                    end
                    ST_SHIFT: begin
                        if (!wr_phase) begin
                            wr_phase <= 1'b1;
                            wea      <= 1'b1;
                            web      <= 1'b1;
                            {north, south, west, east} <= dir_onehot(dir_q);
                        end else begin
                            wr_phase <= 1'b0;
                            wea      <= 1'b0;
                            web      <= 1'b0;
                            {north, south, west, east} <= 4'b0000;
                            remain   <= remain - REM_W'(1);
                        end
                    end
                    ST_ALU: begin
                        remain <= remain - REM_W'(1);
                        if (count == CNT_W'(2))
                            wea <= 1'b1;
                    end
                    default: fsm <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Self-checking bench for pe_array_sequencer: directed scenarios plus a
// randomized command mix checked against expectations computed per command.
module tb_pe_array_sequencer;
    import pe_seq_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 7;
    localparam int LEN_W  = 6;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              op_in = 1'b0;
    logic              wea, web, east, west, south, north, ram_init, done, op_flag;
    logic [ADDR_W-1:0] addra, addrb;
    logic [3:0]        alu_sel;
    logic [CNT_W-1:0]  count;
    logic [1:0]        state;
    logic [DATA_W-1:0] bram_in;
    logic [LEN_W-1:0]  length;

    int   checks = 0;
    int   errors = 0;
    logic exp_op_flag = 1'b0;
    logic [DATA_W-1:0] ld_q[$];

    pe_array_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) ifc ();

    pe_array_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset), .host(ifc), .op_in(op_in),
        .wea(wea), .web(web), .addra(addra), .addrb(addrb),
        .alu_sel(alu_sel), .count(count), .state(state),
        .east(east), .west(west), .south(south), .north(north),
        .ram_init(ram_init), .bram_in(bram_in), .length(length),
        .done(done), .op_flag(op_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int op, input int dir, input int sel, input int a,
                            input int b, input int d, input int len, input int wl);
        ifc.cmd_op      = 2'(op);
        ifc.cmd_dir     = 2'(dir);
        ifc.cmd_alu_sel = 4'(sel);
        ifc.cmd_src_a   = ADDR_W'(a);
        ifc.cmd_src_b   = ADDR_W'(b);
        ifc.cmd_dst     = ADDR_W'(d);
        ifc.cmd_len     = ADDR_W'(len);
        ifc.word_len    = LEN_W'(wl);
        ifc.cmd_valid   = 1'b1;
        chk("cmd_ready_idle", ifc.cmd_ready, 1);
        tick();
        ifc.cmd_valid = 1'b0;
    endtask

    // Beats: load_valid on cycle c after accept is mask[c] (1 beyond bit 31).
    // A beat taken in cycle c shows up as a write in cycle c+1.
    task automatic run_load(input int a, input int len, input logic [31:0] mask);
        int k = 0;
        int cyc = 0;
        int pa = 0;
        logic pend = 1'b0;
        logic lv;
        logic [DATA_W-1:0] pd = '0;
        send_cmd(1, 0, 0, a, 0, 0, len, $urandom_range(0, 63));
        forever begin
            if (k == len && !pend) break;
            if (cyc > 4 * len + 40) begin
                chk("load_timeout_state", state, 0);
                break;
            end
            chk("load_state", state, 3);
            chk("load_done", done, 0);
            chk("load_cmd_ready", ifc.cmd_ready, 0);
            chk("load_wea", wea, pend);
            chk("load_ram_init", ram_init, pend);
            chk("load_web", web, 0);
            if (pend) begin
                chk("load_addra", addra, pa);
                chk("load_bram_in", bram_in, pd);
            end
            chk("load_ready", ifc.load_ready, (k < len));
            lv = (cyc < 32) ? mask[cyc] : 1'b1;
            ifc.load_valid = lv;
            ifc.load_data  = (lv && k < len) ? ld_q[k] : DATA_W'($urandom);
            pend = lv && (k < len);
            if (pend) begin
                pa = (a + k) & AMASK;
                pd = ifc.load_data;
                k++;
            end
            cyc++;
            tick();
        end
        ifc.load_valid = 1'b0;
        chk("load_end_done", done, 1);
        chk("load_end_state", state, 0);
        chk("load_end_wea", wea, 0);
        chk("load_end_ram_init", ram_init, 0);
        tick();
        chk("load_done_once", done, 0);
    endtask

    // Each pair j: READ then WRITE on (a+2j, a+2j+1). With hold, a zero-length
    // LOAD stays offered throughout and must only be taken once idle again.
    task automatic run_shift(input int dir, input int a, input int len, input bit hold);
        send_cmd(2, dir, 0, a, 0, 0, len, $urandom_range(0, 63));
        if (hold) begin
            ifc.cmd_op    = 2'd1;
            ifc.cmd_len   = '0;
            ifc.cmd_valid = 1'b1;
        end
        for (int j = 0; j < len; j++) begin
            for (int ph = 0; ph < 2; ph++) begin
                chk("shift_state", state, 2);
                chk("shift_cmd_ready", ifc.cmd_ready, 0);
                chk("shift_done", done, 0);
                chk("shift_addra", addra, (a + 2 * j) & AMASK);
                chk("shift_addrb", addrb, (a + 2 * j + 1) & AMASK);
                chk("shift_wea", wea, ph);
                chk("shift_web", web, ph);
                chk("shift_strobe", {north, south, west, east}, (ph == 1) ? (32'd1 << dir) : 32'd0);
                tick();
            end
        end
        chk("shift_end_done", done, 1);
        chk("shift_end_state", state, 0);
        chk("shift_end_wea", wea, 0);
        chk("shift_end_strobe", {north, south, west, east}, 0);
        if (hold) begin
            chk("held_cmd_ready", ifc.cmd_ready, 1);
            tick();
            ifc.cmd_valid = 1'b0;
            chk("held_load_done", done, 1);
            chk("held_load_wea", wea, 0);
            chk("held_load_state", state, 0);
        end
        tick();
        chk("shift_done_once", done, 0);
    endtask

    // count 0..2*wl+2; writes to d+(count-3) from count 3; Op taken at last count.
    task automatic run_alu(input int sel, input int a, input int b, input int d,
                           input int wl, input logic opv);
        int last = 2 * wl + 2;
        send_cmd(3, 0, sel, a, b, d, $urandom_range(0, 20), wl);
        for (int c = 0; c <= last; c++) begin
            chk("alu_state", state, 1);
            chk("alu_count", count, c);
            chk("alu_sel", alu_sel, sel);
            chk("alu_length", length, wl);
            chk("alu_done", done, 0);
            chk("alu_web", web, 0);
            chk("alu_op_flag_hold", op_flag, exp_op_flag);
            if (c < 3) begin
                chk("alu_wea_rd", wea, 0);
                chk("alu_addra_rd", addra, a);
                chk("alu_addrb_rd", addrb, b);
            end else begin
                chk("alu_wea_wr", wea, 1);
                chk("alu_addra_wr", addra, (d + c - 3) & AMASK);
            end
            op_in = (c == last) ? opv : 1'($urandom);
            tick();
        end
        exp_op_flag = opv;
        chk("alu_end_done", done, 1);
        chk("alu_end_state", state, 0);
        chk("alu_end_count", count, 0);
        chk("alu_end_wea", wea, 0);
        chk("alu_op_flag", op_flag, exp_op_flag);
        tick();
        chk("alu_done_once", done, 0);
    endtask

    int op, a, len;

    initial begin
        ifc.cmd_valid   = 1'b0;
        ifc.cmd_op      = '0;
        ifc.cmd_dir     = '0;
        ifc.cmd_alu_sel = '0;
        ifc.cmd_src_a   = '0;
        ifc.cmd_src_b   = '0;
        ifc.cmd_dst     = '0;
        ifc.cmd_len     = '0;
        ifc.word_len    = '0;
        ifc.load_valid  = 1'b0;
        ifc.load_data   = '0;

        // Reset while idle.
        #12;
        chk("rst_cmd_ready", ifc.cmd_ready, 1);
        chk("rst_load_ready", ifc.load_ready, 0);
        chk("rst_bus", {wea, web, ram_init, done, op_flag, east, west, south, north}, 0);
        chk("rst_addr", {addra, addrb}, 0);
        chk("rst_misc", {alu_sel, count, state, length}, 0);
        chk("rst_bram_in", bram_in, 0);
        reset = 1'b0;
        tick();

        // NOP completes from IDLE.
        send_cmd(0, 0, 0, 0, 0, 0, 5, 0);
        chk("nop_done", done, 1);
        chk("nop_state", state, 0);
        tick();
        chk("nop_done_once", done, 0);

        // Directed LOAD wrapping past the top of the address space, with a gap.
        ld_q = '{16'hA5A5, 16'h1234, 16'hFFFF};
        run_load(10'h3FE, 3, 32'hFFFF_FFFD);

        // Directed SHIFT north.
        run_shift(3, 10'h010, 2, 1'b0);

        // Directed ALU.
        run_alu(4'h2, 5, 9, 10'h040, 4, 1'b1);

        // Held cmd_valid during SHIFT, followed by a zero-length LOAD.
        run_shift($urandom_range(0, 3), $urandom_range(0, AMASK), 3, 1'b1);

        // Reset in the middle of an ALU command.
        send_cmd(3, 0, 4'h9, 7, 8, 10'h100, 0, 4);
        repeat (5) tick();
        chk("mid_count", count, 5);
        reset = 1'b1;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_wea", wea, 0);
        chk("mid_rst_addra", addra, 0);
        chk("mid_rst_alu_sel", alu_sel, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cmd_ready", ifc.cmd_ready, 1);
        exp_op_flag = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_state", state, 0);
        chk("post_rst_op_flag", op_flag, 0);
        run_shift($urandom_range(0, 3), $urandom_range(0, AMASK), 1, 1'b0);

        // Randomized command mix.
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(1, 3);
            a  = (it % 4 == 0) ? $urandom_range(AMASK - 6, AMASK) : $urandom_range(0, AMASK);
            case (op)
                1: begin
                    len = $urandom_range(0, 6);
                    ld_q.delete();
                    for (int i = 0; i < len; i++) ld_q.push_back(DATA_W'($urandom));
                    run_load(a, len, $urandom);
                end
                2: run_shift($urandom_range(0, 3), a, $urandom_range(0, 5), (it % 5 == 0));
                default: run_alu($urandom_range(0, 15), a, $urandom_range(0, AMASK),
                                 $urandom_range(0, AMASK), $urandom_range(0, 10),
                                 1'($urandom_range(0, 1)));
            endcase
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
- Command-side controller that drives the shared control bus of the PE16 processing-element array.
- Accepts one command at a time: LOAD, SHIFT or ALU.
- Expands each command into the cycle-by-cycle signals every PE consumes: wea/web, addra/addrb, ALU_Sel, count, state, direction strobes, ram_init, BRAM_IN.
- Returns completion plus the array-wide Op flag to the host.

Parameters:
- ADDR_W, 10, BRAM word address width.
- DATA_W, 16, PE word width (BRAM_IN).
- CNT_W, 7, width of the count bus.
- LEN_W, 6, width of the LENGTH bus.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer idle and able to accept a command.
- cmd_op  in  2  0=NOP, 1=LOAD, 2=SHIFT, 3=ALU.
- cmd_dir  in  2  SHIFT direction: 0=east, 1=west, 2=south, 3=north.
- cmd_alu_sel  in  4  ALU function code.
- cmd_src_a  in  ADDR_W  LOAD base / SHIFT base / ALU operand-A address.
- cmd_src_b  in  ADDR_W  ALU operand-B address.
- cmd_dst  in  ADDR_W  ALU result base address.
- cmd_len  in  ADDR_W  LOAD beats, or SHIFT word-pairs.
- word_len  in  LEN_W  serial word length; sampled at command accept, driven out as LENGTH.
- load_valid  in  1  load data beat valid.
- load_ready  out  1  beat accepted this cycle.
- load_data  in  DATA_W  load data.
- op_in  in  1  AND of all PE Op outputs.
- wea, web  out  1 each  BRAM write enables.
- addra, addrb  out  ADDR_W  BRAM addresses.
- alu_sel  out  4  ALU_Sel.
- count  out  CNT_W  ALU phase counter.
- state  out  2  0=IDLE, 1=ALU, 2=SHIFT, 3=LOAD.
- east, west, south, north  out  1 each  one-hot shift strobes.
- ram_init  out  1  selects BRAM_IN as DIA.
- bram_in  out  DATA_W  BRAM_IN.
- length  out  LEN_W  LENGTH.
- done  out  1  one-cycle completion pulse.
- op_flag  out  1  registered Op result of the last ALU command.

Behaviour:
- Reset (asynchronous, any time, including mid-command):
  - FSM returns to IDLE.
  - All outputs 0, except cmd_ready=1.
  - Any partially executed command is abandoned; no done pulse.
- IDLE:
  - cmd_ready=1; a command is accepted on a clk edge where cmd_valid and cmd_ready are both 1.
  - All command fields and word_len are captured into registers at accept.
  - NOP: done pulses on the next cycle; FSM stays in IDLE.
  - cmd_valid while not IDLE is ignored (cmd_ready=0).
- LOAD (state=3):
  - load_ready=1 while the beat index i < cmd_len.
  - On each beat with load_valid=1: ram_init=1, wea=1, addra=src_a+i, bram_in=load_data; i increments.
  - Cycles with load_valid=0: wea=0, ram_init=0, i holds.
  - After beat cmd_len-1, the next cycle pulses done and enters IDLE.
- SHIFT (state=2): two cycles per pair j = 0..cmd_len-1.
  - READ cycle: addra=src_a+2j, addrb=src_a+2j+1; wea=web=0; no direction strobe.
  - WRITE cycle: same addresses; wea=web=1; the strobe selected by cmd_dir is asserted alone.
  - done pulses after the final WRITE cycle.
- ALU (state=1):
  - count runs 0..2*length+2, one step per cycle; alu_sel is held throughout.
  - count 0..2: addra=src_b... no: addra=src_a, addrb=src_b, wea=web=0 (PE captures q regs at count==2).
  - count >= 3: wea=1, web=0, addra=dst+(count-3).
  - At the last count, op_in is registered into op_flag.
  - Next cycle: count=0, done pulses, FSM enters IDLE.
- Zero-size commands: cmd_len=0 for LOAD or SHIFT pulses done the cycle after accept with no BRAM writes. word_len=0 for ALU runs count 0..2 with no writes.
- Address wrap: all address arithmetic is modulo 2^ADDR_W.
- Direction strobes are mutually exclusive and are 0 outside SHIFT WRITE cycles.

Decomposition:
- Package pe_seq_pkg holds:
  - opcode encodings;
  - state encodings;
  - direction encodings;
  - ADDR_W, DATA_W, CNT_W, LEN_W defaults.
- One sub-module, pe_seq_addr_gen: holds the base, index and count registers, and produces addra/addrb/count from FSM step and clear controls.

Test Plan:
- Reset while idle → all outputs 0, cmd_ready=1.
- LOAD, src_a=0x3FE, cmd_len=3, data 0xA5A5/0x1234/0xFFFF with a one-cycle load_valid gap → writes at 0x3FE, 0x3FF, 0x000 with matching bram_in; ram_init high only on beats; one done pulse.
- SHIFT, dir=north, src_a=0x010, cmd_len=2 → four cycles with address pairs (10,11) R, (10,11) W, (12,13) R, (12,13) W; north high only on W cycles; done after the 4th cycle.
- ALU, alu_sel=4'h2, src_a=5, src_b=9, dst=0x40, word_len=4, op_in=1 at the last count → count 0..10; wea low at count 0–2; addra 0x40..0x47 at count 3..10; op_flag=1; done once.
- Assert reset at count=5 of an ALU command → outputs 0 immediately; no done; a new command is accepted after reset deasserts.
- cmd_valid held high during a SHIFT → second command not accepted until cmd_ready returns; LOAD with cmd_len=0 → done one cycle after accept, no wea.
